// File: rtl/parking_pkg.sv
// Shared constants and FSM encoding for the parking slot controller.
package parking_pkg;

    localparam int NSLOT        = 6;
    localparam int RATE         = 10;
    localparam int TW           = 11;
    localparam int MIN_PER_HOUR = 60;
    localparam int SLOT_W       = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANT_IN = 3'd1,
        LOAD     = 3'd2,
        DIVIDE   = 3'd3,
        DONE_OUT = 3'd4
    } state_e;

    // Width needed to count the started hours of the longest possible stay.
    function automatic int hours_width(input int tw);
        return $clog2(((1 << tw) - 1) / MIN_PER_HOUR + 2);
    endfunction

endpackage

// File: rtl/fee_divider.sv
// Iterative ceiling divider: counts started hours in a parking duration by
// repeatedly taking one hour (or whatever is left) off the remaining minutes.
module fee_divider #(
    parameter int TW = parking_pkg::TW,
    parameter int HW = parking_pkg::hours_width(parking_pkg::TW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [TW-1:0] use_i,
    output logic [HW-1:0] hours_o,
    output logic          done_o
);
    import parking_pkg::*;

    logic [TW-1:0] rem_q, rem_d;
    logic [HW-1:0] hours_q, hours_d;

    // Load a new duration, or consume one hour per step while minutes remain.
    always_comb begin
        rem_d   = rem_q;
        hours_d = hours_q;
        if (load_i) begin
            rem_d   = use_i;
            hours_d = '0;
        end else if (step_i && (rem_q != '0)) begin
            if (rem_q <= TW'(MIN_PER_HOUR)) begin
                rem_d = '0;
            end else begin
                rem_d = rem_q - TW'(MIN_PER_HOUR);
            end
            hours_d = hours_q + 1'b1;
        end
    end

    // Divider registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            hours_q <= '0;
        end else begin
            rem_q   <= rem_d;
            hours_q <= hours_d;
        end
    end

    assign hours_o = hours_q;
    assign done_o  = (rem_q == '0);

endmodule

// File: rtl/parking_slot_controller.sv
// Parking slot controller: allocates slots on entry, timestamps them, and on
// exit computes a fee of RATE per started hour using an iterative divider.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | sample and arbitrate entry/exit requests
// GRANT_IN | in_ack; allocate lowest free slot and stamp it (or reject)
// LOAD     | load parking duration of the exiting slot into the divider
// DIVIDE   | count started hours, one per cycle, until nothing remains
// DONE_OUT | out_ack with fee/out_err; free the slot on a valid exit
module parking_slot_controller #(
    parameter int NSLOT = parking_pkg::NSLOT,
    parameter int RATE  = parking_pkg::RATE,
    parameter int TW    = parking_pkg::TW
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [TW-1:0]                 timer,
    input  logic                          in_req,
    output logic                          in_ack,
    output logic [parking_pkg::SLOT_W-1:0] in_slot,
    input  logic                          out_req,
    input  logic [parking_pkg::SLOT_W-1:0] out_slot,
    output logic                          out_ack,
    output logic                          out_err,
    output logic [TW-1:0]                 fee,
    output logic [NSLOT-1:0]              occupied,
    output logic                          full
);
    import parking_pkg::*;

    localparam int HW = hours_width(TW);

    state_e              state_q, state_d;
    logic                ptr_exit_q, ptr_exit_d;
    logic [NSLOT-1:0]    occ_q, occ_d;
    logic [TW-1:0]       stamp_q [NSLOT];
    logic [TW-1:0]       stamp_d [NSLOT];
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                err_q, err_d;
    logic [TW-1:0]       fee_q, fee_d;

    logic [SLOT_W-1:0]   free_slot;
    logic                exit_ok;
    logic [TW-1:0]       stamp_sel;
    logic [TW-1:0]       use_val;
    logic                take_out;
    logic                div_load;
    logic                div_step;
    logic [HW-1:0]       div_hours;
    logic                div_done;
    logic [TW-1:0]       fee_calc;

    // Lowest-numbered free slot; zero when every slot is taken.
    always_comb begin
        free_slot = '0;
        for (int k = NSLOT - 1; k >= 0; k--) begin
            if (!occ_q[k]) begin
                free_slot = SLOT_W'(k + 1);
            end
        end
    end

    // An exit is valid only for an in-range slot that is currently occupied.
    always_comb begin
        exit_ok = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
            if ((out_slot == SLOT_W'(k + 1)) && occ_q[k]) begin
                exit_ok = 1'b1;
            end
        end
    end

    // Stamp of the slot latched for the exit in progress.
    always_comb begin
        stamp_sel = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (slot_q == SLOT_W'(k + 1)) begin
                stamp_sel = stamp_q[k];
            end
        end
    end

    // Modulo subtraction handles a timer that wrapped while the car was parked.
    assign use_val  = timer - stamp_sel;
    assign fee_calc = TW'(int'(div_hours) * RATE);

    fee_divider #(
        .TW (TW),
        .HW (HW)
    ) u_fee_divider (
        .clk     (clk),
        .rst     (rst),
        .load_i  (div_load),
        .step_i  (div_step),
        .use_i   (use_val),
        .hours_o (div_hours),
        .done_o  (div_done)
    );

    // Next-state, arbitration and slot bookkeeping.
    always_comb begin
        state_d    = state_q;
        ptr_exit_d = ptr_exit_q;
        occ_d      = occ_q;
        stamp_d    = stamp_q;
        slot_d     = slot_q;
        err_d      = err_q;
        fee_d      = fee_q;
        div_load   = 1'b0;
        div_step   = 1'b0;
        take_out   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Contested requests alternate; an uncontested one leaves the pointer alone.
                take_out = out_req && (!in_req || ptr_exit_q);
                if (in_req && out_req) begin
                    ptr_exit_d = !ptr_exit_q;
                end
                if (take_out) begin
                    slot_d = out_slot;
                    if (exit_ok) begin
                        err_d   = 1'b0;
                        state_d = LOAD;
                    end else begin
                        err_d   = 1'b1;
                        fee_d   = '0;
                        state_d = DONE_OUT;
                    end
                end else if (in_req) begin
                    state_d = GRANT_IN;
                end
            end
            GRANT_IN: begin
                // free_slot is zero when full, so a rejected entry touches nothing.
                for (int k = 0; k < NSLOT; k++) begin
                    if (free_slot == SLOT_W'(k + 1)) begin
                        occ_d[k]   = 1'b1;
                        stamp_d[k] = timer;
                    end
                end
                state_d = IDLE;
            end
            LOAD: begin
                div_load = 1'b1;
                state_d  = DIVIDE;
            end
            DIVIDE: begin
                if (div_done) begin
                    fee_d   = fee_calc;
                    state_d = DONE_OUT;
                end else begin
                    div_step = 1'b1;
                end
            end
            DONE_OUT: begin
                if (!err_q) begin
                    for (int k = 0; k < NSLOT; k++) begin
                        if (slot_q == SLOT_W'(k + 1)) begin
                            occ_d[k]   = 1'b0;
                            stamp_d[k] = '0;
                        end
                    end
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and slot table registers; reset aborts any exit in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_exit_q <= 1'b1;
            occ_q      <= '0;
            for (int k = 0; k < NSLOT; k++) begin
                stamp_q[k] <= '0;
            end
            slot_q     <= '0;
            err_q      <= 1'b0;
            fee_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_exit_q <= ptr_exit_d;
            occ_q      <= occ_d;
            stamp_q    <= stamp_d;
            slot_q     <= slot_d;
            err_q      <= err_d;
            fee_q      <= fee_d;
        end
    end

    assign in_ack   = (state_q == GRANT_IN);
    assign in_slot  = in_ack ? free_slot : '0;
    assign out_ack  = (state_q == DONE_OUT);
    assign out_err  = out_ack && err_q;
    assign fee      = fee_q;
    assign occupied = occ_q;
    assign full     = &occ_q;

endmodule

// File: tb/tb_parking_slot_controller.sv
// Directed and randomized bench for the parking slot controller, with a
// slot-table reference model that works in minutes and whole hours.
module tb_parking_slot_controller;

    localparam int NSLOT = 6;
    localparam int RATE  = 10;
    localparam int TW    = 11;
    localparam int TMASK = (1 << TW) - 1;

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic [TW-1:0]    timer    = '0;
    logic             in_req   = 1'b0;
    logic             in_ack;
    logic [2:0]       in_slot;
    logic             out_req  = 1'b0;
    logic [2:0]       out_slot = '0;
    logic             out_ack;
    logic             out_err;
    logic [TW-1:0]    fee;
    logic [NSLOT-1:0] occupied;
    logic             full;

    int checks = 0;
    int errors = 0;

    bit m_occ   [1:NSLOT];
    int m_stamp [1:NSLOT];
    bit m_ptr_exit;

    parking_slot_controller #(
        .NSLOT (NSLOT),
        .RATE  (RATE),
        .TW    (TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .timer    (timer),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .in_slot  (in_slot),
        .out_req  (out_req),
        .out_slot (out_slot),
        .out_ack  (out_ack),
        .out_err  (out_err),
        .fee      (fee),
        .occupied (occupied),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic m_reset();
        for (int k = 1; k <= NSLOT; k++) begin
            m_occ[k]   = 1'b0;
            m_stamp[k] = 0;
        end
        m_ptr_exit = 1'b1;
    endtask

    function automatic logic [NSLOT-1:0] m_occ_vec();
        logic [NSLOT-1:0] v;
        v = '0;
        for (int k = 1; k <= NSLOT; k++) v[k-1] = m_occ[k];
        return v;
    endfunction

    function automatic int m_free();
        for (int k = 1; k <= NSLOT; k++) if (!m_occ[k]) return k;
        return 0;
    endfunction

    task automatic m_exit(input int s, input int t, output bit err, output int fee_e, output int lat);
        bit ok;
        int use_m;
        int h;
        ok = 1'b0;
        if (s >= 1 && s <= NSLOT) ok = m_occ[s];
        if (ok) begin
            use_m = (t - m_stamp[s]) & TMASK;
            h     = (use_m + 59) / 60;
            err   = 1'b0;
            fee_e = h * RATE;
            lat   = h + 3;
            m_occ[s]   = 1'b0;
            m_stamp[s] = 0;
        end else begin
            err   = 1'b1;
            fee_e = 0;
            lat   = 1;
        end
    endtask

    // ---------------- handshake helpers ----------------
    task automatic wait_ack(output bit gi, output bit go, output int n);
        gi = 1'b0;
        go = 1'b0;
        n  = 0;
        while (!gi && !go && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            gi = (in_ack === 1'b1);
            go = (out_ack === 1'b1);
        end
    endtask

    // in_req already high and the controller idle in the current cycle.
    task automatic finish_entry(output int slot_obs);
        bit gi, go;
        int n;
        int exp_slot;
        exp_slot = m_free();
        wait_ack(gi, go, n);
        chk("in_ack_seen", gi, 1);
        chk("in_no_out_ack", go, 0);
        chk("in_lat", n, 1);
        chk("in_slot", in_slot, exp_slot);
        slot_obs = in_slot;
        if (exp_slot != 0) begin
            m_occ[exp_slot]   = 1'b1;
            m_stamp[exp_slot] = int'(timer);
        end
        @(posedge clk);
        #1;
        in_req = 1'b0;
        chk("in_occupied", occupied, m_occ_vec());
        chk("in_full", full, &m_occ_vec());
    endtask

    // out_req/out_slot already set and the controller idle in the current cycle.
    task automatic finish_exit(input int s, output int fee_obs, output int lat_obs);
        bit gi, go;
        int n;
        bit e_err;
        int e_fee, e_lat;
        m_exit(s, int'(timer), e_err, e_fee, e_lat);
        wait_ack(gi, go, n);
        chk("out_ack_seen", go, 1);
        chk("out_no_in_ack", gi, 0);
        chk("out_lat", n, e_lat);
        chk("out_err", out_err, e_err);
        chk("out_fee", fee, e_fee);
        fee_obs = fee;
        lat_obs = n;
        @(posedge clk);
        #1;
        out_req = 1'b0;
        chk("fee_held", fee, e_fee);
        chk("out_occupied", occupied, m_occ_vec());
        chk("out_full", full, &m_occ_vec());
    endtask

    task automatic do_entry(input int t, output int slot_obs);
        timer  = TW'(t);
        in_req = 1'b1;
        finish_entry(slot_obs);
    endtask

    task automatic do_exit(input int s, input int t, output int fee_obs, output int lat_obs);
        timer    = TW'(t);
        out_slot = 3'(s);
        out_req  = 1'b1;
        finish_exit(s, fee_obs, lat_obs);
    endtask

    task automatic contest(input int s, input int t);
        int sl, f, l;
        timer    = TW'(t);
        out_slot = 3'(s);
        in_req   = 1'b1;
        out_req  = 1'b1;
        if (m_ptr_exit) begin
            m_ptr_exit = 1'b0;
            finish_exit(s, f, l);
            finish_entry(sl);
        end else begin
            m_ptr_exit = 1'b1;
            finish_entry(sl);
            finish_exit(s, f, l);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        in_req  = 1'b0;
        out_req = 1'b0;
        #1;
        chk("rst_async_out_ack", out_ack, 0);
        chk("rst_async_occ", occupied, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ack", in_ack, 0);
        chk("rst_in_slot", in_slot, 0);
        chk("rst_out_ack", out_ack, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_fee", fee, 0);
        chk("rst_occupied", occupied, 0);
        chk("rst_full", full, 0);
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        int sl, f, l, r, t, s, any_ack;
        int cand[$];

        m_reset();
        do_reset();

        // Fill every slot, then one more entry must be rejected.
        for (int i = 0; i < 7; i++) begin
            do_entry(10 * i, sl);
            chk("fill_slot", sl, (i < NSLOT) ? i + 1 : 0);
        end
        chk("fill_full", full, 1);
        chk("fill_occ", occupied, 6'h3f);

        for (int k = 1; k <= NSLOT; k++) do_exit(k, 100 + 37 * k, f, l);

        // Fee arithmetic corner cases.
        do_entry(100, sl);
        chk("e130_slot", sl, 1);
        do_exit(1, 230, f, l);
        chk("e130_fee", f, 30);
        chk("e130_lat", l, 6);
        do_entry(300, sl);
        do_exit(1, 420, f, l);
        chk("e120_fee", f, 20);
        do_entry(500, sl);
        do_exit(1, 500, f, l);
        chk("e0_fee", f, 0);
        chk("e0_lat", l, 3);
        do_entry(2000, sl);
        do_exit(1, 50, f, l);
        chk("wrap_fee", f, 20);

        // Contested requests after reset: exit first, then alternation.
        do_reset();
        contest(5, 700);
        contest(3, 800);
        contest(1, 900);
        do_exit(5, 901, f, l);
        chk("free5_err_fee", f, 0);

        // Reset in the middle of a long division.
        do_reset();
        do_entry(0, sl);
        timer    = TW'(600);
        out_slot = 3'd1;
        out_req  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_div_no_ack", out_ack, 0);
        rst     = 1'b1;
        out_req = 1'b0;
        #1;
        chk("mid_div_occ", occupied, 0);
        chk("mid_div_full", full, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        any_ack = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_ack !== 1'b0) any_ack = 1;
        end
        chk("mid_div_ack_after", any_ack, 0);
        do_entry(1000, sl);
        chk("mid_div_next_slot", sl, 1);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            t = $urandom_range(0, TMASK);
            if (r < 40) begin
                do_entry(t, sl);
            end else if (r < 80) begin
                cand.delete();
                for (int k = 1; k <= NSLOT; k++) if (m_occ[k]) cand.push_back(k);
                if (cand.size() > 0) s = cand[$urandom_range(0, cand.size() - 1)];
                else s = $urandom_range(0, 7);
                do_exit(s, t, f, l);
            end else if (r < 90) begin
                do_exit($urandom_range(0, 7), t, f, l);
            end else begin
                contest($urandom_range(1, NSLOT), t);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
